// File: rtl/sc64.sv
// rtl/sc64.sv - shared device IDs, error causes and FSM states for the CPU bus fabric
package sc64;

   localparam int DEFAULT_ID_LSB = 24;
   localparam int ID_WIDTH       = 4;
   localparam int MAX_DEVICES    = 16;

   // Slot assignments used by cpu_soc when wiring devices to the fabric
   localparam logic [ID_WIDTH-1:0] DEV_ID_ROM   = 4'd0;
   localparam logic [ID_WIDTH-1:0] DEV_ID_RAM   = 4'd1;
   localparam logic [ID_WIDTH-1:0] DEV_ID_UART  = 4'd2;
   localparam logic [ID_WIDTH-1:0] DEV_ID_TIMER = 4'd3;
   localparam logic [ID_WIDTH-1:0] DEV_ID_GPIO  = 4'd4;
   localparam logic [ID_WIDTH-1:0] DEV_ID_FLASH = 4'd6;

   typedef enum logic [1:0] {
      NONE     = 2'd0,
      UNMAPPED = 2'd1,
      TIMEOUT  = 2'd2,
      OVERRUN  = 2'd3
   } bus_error_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_ERR_ACK = 2'd3
   } fabric_state_e;

endpackage

// File: rtl/cpu_bus_timeout.sv
// rtl/cpu_bus_timeout.sv - device response watchdog for the CPU bus fabric
module cpu_bus_timeout #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Count saturates at the limit so expired stays asserted until reloaded
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/cpu_bus_fabric.sv
// rtl/cpu_bus_fabric.sv - single-master CPU bus fabric decoding a 4-bit device ID to one-hot slot requests
module cpu_bus_fabric
   import sc64::*;
#(
   parameter int          NUM_DEVICES    = 16,
   parameter logic [15:0] DEVICE_MASK    = 16'hFFFF,
   parameter int          ID_LSB         = DEFAULT_ID_LSB,
   parameter int          TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERROR_DATA     = 32'hFFFF_FFFF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        m_request,
   input  logic [3:0]                  m_wmask,
   input  logic [31:0]                 m_address,
   input  logic [31:0]                 m_wdata,
   output logic                        m_ack,
   output logic [31:0]                 m_rdata,
   output logic [NUM_DEVICES-1:0]      d_request,
   output logic [3:0]                  d_wmask,
   output logic [31:0]                 d_address,
   output logic [31:0]                 d_wdata,
   input  logic [NUM_DEVICES-1:0]      d_ack,
   input  logic [NUM_DEVICES-1:0][31:0] d_rdata,
   input  logic                        err_clear,
   output logic                        err,
   output logic [1:0]                  err_code,
   output logic [31:0]                 err_address
);

   fabric_state_e state, state_next;
   bus_error_e    err_code_q, err_cause;

   logic [ID_WIDTH-1:0] m_id, id_q;
   logic                m_mapped;
   logic [15:0]         ack_pad;
   logic [15:0][31:0]   rdata_pad;
   logic [15:0]         req_pad;
   logic                ack_sel;
   logic                latch_req;
   logic                tmo_load, tmo_enable, tmo_expired;
   logic                m_ack_next;
   logic [31:0]         m_rdata_next;
   logic                err_event;
   logic [31:0]         err_addr_event;

   assign m_id     = m_address[ID_LSB+ID_WIDTH-1:ID_LSB];
   assign id_q     = d_address[ID_LSB+ID_WIDTH-1:ID_LSB];
   assign m_mapped = ({28'd0, m_id} < 32'(NUM_DEVICES)) && DEVICE_MASK[m_id];

   // Widen the slot buses to 16 so a 4-bit ID can index them for any NUM_DEVICES
   always_comb begin
      ack_pad   = '0;
      rdata_pad = '0;
      for (int i = 0; i < NUM_DEVICES; i++) begin
         ack_pad[i]   = d_ack[i];
         rdata_pad[i] = d_rdata[i];
      end
   end

   assign ack_sel = ack_pad[id_q];

   always_comb begin
      req_pad = '0;
      if (state == ST_ISSUE) begin
         req_pad = 16'd1 << id_q;
      end
   end

   assign d_request = req_pad[NUM_DEVICES-1:0];

   cpu_bus_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .load   (tmo_load),
      .enable (tmo_enable),
      .expired(tmo_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // An ack seen while d_request is still high completes at once, giving the two-cycle minimum latency
   always_comb begin
      state_next     = state;
      latch_req      = 1'b0;
      tmo_load       = 1'b0;
      tmo_enable     = 1'b0;
      m_ack_next     = 1'b0;
      m_rdata_next   = '0;
      err_event      = 1'b0;
      err_cause      = NONE;
      err_addr_event = '0;

      case (state)
         ST_IDLE: begin
            if (m_request) begin
               latch_req = 1'b1;
               if (m_mapped) begin
                  state_next = ST_ISSUE;
               end else begin
                  state_next     = ST_ERR_ACK;
                  err_event      = 1'b1;
                  err_cause      = UNMAPPED;
                  err_addr_event = m_address;
               end
            end
         end
         ST_ISSUE: begin
            tmo_load = 1'b1;
            if (ack_sel) begin
               m_ack_next   = 1'b1;
               m_rdata_next = rdata_pad[id_q];
               state_next   = ST_IDLE;
            end else begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            tmo_enable = 1'b1;
            if (ack_sel) begin
               m_ack_next   = 1'b1;
               m_rdata_next = rdata_pad[id_q];
               state_next   = ST_IDLE;
            end else if (tmo_expired) begin
               state_next     = ST_ERR_ACK;
               err_event      = 1'b1;
               err_cause      = TIMEOUT;
               err_addr_event = d_address;
            end
         end
         ST_ERR_ACK: begin
            m_ack_next   = 1'b1;
            m_rdata_next = ERROR_DATA;
            state_next   = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // A timeout in the same cycle as a dropped request takes precedence
      if (m_request && (state != ST_IDLE) && !err_event) begin
         err_event      = 1'b1;
         err_cause      = OVERRUN;
         err_addr_event = m_address;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_ack       <= 1'b0;
         m_rdata     <= '0;
         d_wmask     <= '0;
         d_address   <= '0;
         d_wdata     <= '0;
         err         <= 1'b0;
         err_code_q  <= NONE;
         err_address <= '0;
      end else begin
         m_ack   <= m_ack_next;
         m_rdata <= m_rdata_next;
         if (latch_req) begin
            d_wmask   <= m_wmask;
            d_address <= m_address;
            d_wdata   <= m_wdata;
         end
         // A new error beats err_clear in the same cycle; otherwise only the first error is kept
         if (err_event && (!err || err_clear)) begin
            err         <= 1'b1;
            err_code_q  <= err_cause;
            err_address <= err_addr_event;
         end else if (err_clear) begin
            err         <= 1'b0;
            err_code_q  <= NONE;
            err_address <= '0;
         end
      end
   end

   assign err_code = err_code_q;

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// tb/tb_cpu_bus_fabric.sv - directed self-checking bench for cpu_bus_fabric
module tb_cpu_bus_fabric;

   logic              clk = 1'b0;
   logic              reset;
   logic              m_request;
   logic [3:0]        m_wmask;
   logic [31:0]       m_address;
   logic [31:0]       m_wdata;
   logic              m_ack;
   logic [31:0]       m_rdata;
   logic [15:0]       d_request;
   logic [3:0]        d_wmask;
   logic [31:0]       d_address;
   logic [31:0]       d_wdata;
   logic [15:0]       d_ack;
   logic [15:0][31:0] d_rdata;
   logic              err_clear;
   logic              err;
   logic [1:0]        err_code;
   logic [31:0]       err_address;

   int errors = 0;
   int checks = 0;

   cpu_bus_fabric #(
      .NUM_DEVICES   (16),
      .DEVICE_MASK   (16'hFFDF),
      .ID_LSB        (24),
      .TIMEOUT_CYCLES(8),
      .ERROR_DATA    (32'hFFFF_FFFF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .m_request  (m_request),
      .m_wmask    (m_wmask),
      .m_address  (m_address),
      .m_wdata    (m_wdata),
      .m_ack      (m_ack),
      .m_rdata    (m_rdata),
      .d_request  (d_request),
      .d_wmask    (d_wmask),
      .d_address  (d_address),
      .d_wdata    (d_wdata),
      .d_ack      (d_ack),
      .d_rdata    (d_rdata),
      .err_clear  (err_clear),
      .err        (err),
      .err_code   (err_code),
      .err_address(err_address)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic request(input logic [31:0] addr, input logic [3:0] wmask, input logic [31:0] wdata);
      m_request = 1'b1;
      m_address = addr;
      m_wmask   = wmask;
      m_wdata   = wdata;
   endtask

   initial begin
      reset     = 1'b1;
      m_request = 1'b0;
      m_wmask   = '0;
      m_address = '0;
      m_wdata   = '0;
      d_ack     = '0;
      d_rdata   = '0;
      err_clear = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      check("rst_m_ack", 32'(m_ack), 32'd0);
      check("rst_m_rdata", m_rdata, 32'd0);
      check("rst_d_request", 32'(d_request), 32'd0);
      check("rst_d_address", d_address, 32'd0);
      check("rst_d_wmask", 32'(d_wmask), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_err_address", err_address, 32'd0);

      // Read slot 3, ack while d_request is high
      request(32'h0300_0010, 4'h0, 32'h0);
      tick();
      m_request = 1'b0;
      check("rd3_d_request", 32'(d_request), 32'h0008);
      check("rd3_d_address", d_address, 32'h0300_0010);
      check("rd3_m_ack_early", 32'(m_ack), 32'd0);
      d_ack      = 16'h0008;
      d_rdata[3] = 32'h1234_5678;
      tick();
      d_ack = '0;
      check("rd3_m_ack", 32'(m_ack), 32'd1);
      check("rd3_m_rdata", m_rdata, 32'h1234_5678);
      check("rd3_d_request_off", 32'(d_request), 32'd0);
      tick();
      check("rd3_m_ack_single", 32'(m_ack), 32'd0);
      check("rd3_m_rdata_zero", m_rdata, 32'd0);

      // Write slot 6; a wrong-slot ack first, then the real one in WAIT
      request(32'h0600_0004, 4'b0101, 32'hA5A5_0F0F);
      tick();
      m_request = 1'b0;
      check("wr6_d_request", 32'(d_request), 32'h0040);
      check("wr6_d_wmask", 32'(d_wmask), 32'h5);
      check("wr6_d_wdata", d_wdata, 32'hA5A5_0F0F);
      d_ack      = 16'h0001;
      d_rdata[0] = 32'hDEAD_0000;
      tick();
      check("wr6_wrong_slot_ignored", 32'(m_ack), 32'd0);
      d_ack      = 16'h0040;
      d_rdata[6] = 32'h0000_0066;
      tick();
      d_ack = '0;
      check("wr6_m_ack", 32'(m_ack), 32'd1);
      check("wr6_m_rdata", m_rdata, 32'h0000_0066);
      tick();
      check("wr6_m_ack_single", 32'(m_ack), 32'd0);

      // Unmapped slot 5
      request(32'h0500_0000, 4'h0, 32'h0);
      tick();
      m_request = 1'b0;
      check("unm_m_ack_early", 32'(m_ack), 32'd0);
      check("unm_d_request", 32'(d_request), 32'd0);
      tick();
      check("unm_m_ack", 32'(m_ack), 32'd1);
      check("unm_m_rdata", m_rdata, 32'hFFFF_FFFF);
      check("unm_err", 32'(err), 32'd1);
      check("unm_err_code", 32'(err_code), 32'd1);
      check("unm_err_address", err_address, 32'h0500_0000);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check("unm_clear_err", 32'(err), 32'd0);
      check("unm_clear_code", 32'(err_code), 32'd0);

      // Timeout on slot 2 (limit 8), then a late ack
      request(32'h0200_0000, 4'h0, 32'h0);
      tick();
      m_request = 1'b0;
      check("tmo_d_request", 32'(d_request), 32'h0004);
      repeat (9) tick();
      check("tmo_m_ack_early", 32'(m_ack), 32'd0);
      tick();
      check("tmo_m_ack", 32'(m_ack), 32'd1);
      check("tmo_m_rdata", m_rdata, 32'hFFFF_FFFF);
      check("tmo_err_code", 32'(err_code), 32'd2);
      check("tmo_err_address", err_address, 32'h0200_0000);
      repeat (3) tick();
      d_ack      = 16'h0004;
      d_rdata[2] = 32'h7777_7777;
      tick();
      d_ack = '0;
      check("tmo_late_ack_1", 32'(m_ack), 32'd0);
      tick();
      check("tmo_late_ack_2", 32'(m_ack), 32'd0);
      check("tmo_err_kept", 32'(err_code), 32'd2);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check("tmo_clear_err", 32'(err), 32'd0);

      // Overrun while in WAIT on slot 4
      request(32'h0400_0020, 4'h0, 32'h0);
      tick();
      m_request = 1'b0;
      check("ovr_d_request", 32'(d_request), 32'h0010);
      tick();
      request(32'h0700_0000, 4'h3, 32'h1111_2222);
      tick();
      m_request = 1'b0;
      check("ovr_err", 32'(err), 32'd1);
      check("ovr_err_code", 32'(err_code), 32'd3);
      check("ovr_err_address", err_address, 32'h0700_0000);
      check("ovr_d_address_kept", d_address, 32'h0400_0020);
      d_ack      = 16'h0010;
      d_rdata[4] = 32'hCAFE_0004;
      tick();
      d_ack = '0;
      check("ovr_m_ack", 32'(m_ack), 32'd1);
      check("ovr_m_rdata", m_rdata, 32'hCAFE_0004);
      tick();
      check("ovr_m_ack_single", 32'(m_ack), 32'd0);
      check("ovr_dropped_no_issue", 32'(d_request), 32'd0);

      // New error in the same cycle as err_clear is latched
      err_clear = 1'b1;
      request(32'h0500_0040, 4'h0, 32'h0);
      tick();
      err_clear = 1'b0;
      m_request = 1'b0;
      check("clr_race_err", 32'(err), 32'd1);
      check("clr_race_code", 32'(err_code), 32'd1);
      check("clr_race_address", err_address, 32'h0500_0040);
      tick();
      check("clr_race_m_ack", 32'(m_ack), 32'd1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check("clr_err", 32'(err), 32'd0);
      check("clr_err_code", 32'(err_code), 32'd0);
      check("clr_err_address", err_address, 32'd0);

      // Reset during WAIT abandons the transaction
      request(32'h0300_0000, 4'hF, 32'h0000_0001);
      tick();
      m_request = 1'b0;
      check("rstw_d_request", 32'(d_request), 32'h0008);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstw_d_request_off", 32'(d_request), 32'd0);
      check("rstw_d_wmask", 32'(d_wmask), 32'd0);
      check("rstw_d_address", d_address, 32'd0);
      check("rstw_d_wdata", d_wdata, 32'd0);
      d_ack      = 16'h0008;
      d_rdata[3] = 32'h3333_3333;
      tick();
      d_ack = '0;
      check("rstw_no_m_ack_1", 32'(m_ack), 32'd0);
      tick();
      check("rstw_no_m_ack_2", 32'(m_ack), 32'd0);
      check("rstw_m_rdata", m_rdata, 32'd0);
      check("rstw_err", 32'(err), 32'd0);

      // Simultaneous acks from slots 1 and 2, slot 2 selected
      request(32'h0200_0100, 4'h0, 32'h0);
      tick();
      m_request  = 1'b0;
      d_ack      = 16'h0006;
      d_rdata[1] = 32'h1111_1111;
      d_rdata[2] = 32'h2222_2222;
      tick();
      d_ack = '0;
      check("dual_m_ack", 32'(m_ack), 32'd1);
      check("dual_m_rdata", m_rdata, 32'h2222_2222);
      tick();
      check("dual_m_ack_single", 32'(m_ack), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_bus_fabric.md
CPU_BUS_FABRIC -- requirements
Module: cpu_bus_fabric

Interface
REQ-001 SHALL have parameter NUM_DEVICES, default 16: number of device slots, range 1..16.
REQ-002 SHALL have parameter DEVICE_MASK, default 16'hFFFF: bit n=1 means slot n is populated.
REQ-003 SHALL have parameter ID_LSB, default 24: lowest address bit of the 4-bit device ID field, address[ID_LSB+3:ID_LSB].
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256: device response limit, range 2..65535.
REQ-005 SHALL have parameter ERROR_DATA, default 32'hFFFF_FFFF: rdata returned on an error completion.
REQ-006 sys.clk  input  1  single clock; all logic on its rising edge.
REQ-007 sys.reset  input  1  synchronous, active-high reset.
REQ-008 m_request  input  1  single-cycle transaction request pulse.
REQ-009 m_wmask  input  4  byte write enables; 0 = read.
REQ-010 m_address  input  32  byte address.
REQ-011 m_wdata  input  32  write data.
REQ-012 m_ack  output  1  single-cycle completion pulse.
REQ-013 m_rdata  output  32  read data, valid only while m_ack=1.
REQ-014 d_request  output  NUM_DEVICES  one-hot device request pulse.
REQ-015 d_wmask / d_address / d_wdata  output  4/32/32  registered copies shared by all slots.
REQ-016 d_ack  input  NUM_DEVICES  per-slot completion pulses.
REQ-017 d_rdata  input  NUM_DEVICES x 32  per-slot read data.
REQ-018 err_clear  input  1  clears the sticky error state.
REQ-019 err / err_code / err_address  output  1/2/32  sticky error flag, first-error cause, first-error address.

Function
REQ-020 SHALL run FSM states IDLE, ISSUE, WAIT, ERR_ACK.
REQ-021 IDLE + m_request: latch wmask/address/wdata, decode ID; go to ISSUE if the ID is < NUM_DEVICES and its DEVICE_MASK bit is set, else to ERR_ACK with cause UNMAPPED.
REQ-022 ISSUE: pulse d_request[ID] for exactly one cycle, load the timeout counter to 0, go to WAIT.
REQ-023 WAIT: on d_ack[ID], next cycle pulse m_ack with m_rdata = registered d_rdata[ID] (writes included), return to IDLE.
REQ-024 Minimum latency: m_request at cycle N, d_request at N+1, d_ack at N+1 gives m_ack at N+2.
REQ-025 WAIT: when the counter reaches TIMEOUT_CYCLES-1 without d_ack[ID], go to ERR_ACK with cause TIMEOUT.
REQ-026 ERR_ACK: pulse m_ack with m_rdata=ERROR_DATA for one cycle, return to IDLE.
REQ-027 d_ack from non-selected slots, and any d_ack outside WAIT, SHALL be ignored (late acks after timeout are discarded).
REQ-028 m_request outside IDLE SHALL be dropped, no ack generated, cause OVERRUN recorded.
REQ-029 err_code encoding: 0 NONE, 1 UNMAPPED, 2 TIMEOUT, 3 OVERRUN.
REQ-030 The first error sets err=1 and latches err_code and err_address; later errors leave them unchanged until cleared.
REQ-031 err_clear clears err, err_code and err_address; an error in the same cycle as err_clear wins and is latched.
REQ-032 m_ack SHALL never be high for two consecutive cycles; d_request SHALL have at most one bit set.
REQ-033 m_rdata SHALL be 0 whenever m_ack=0.

Reset
REQ-034 On reset: FSM=IDLE; m_ack=0; m_rdata=0; d_request=0; d_wmask=0; d_address=0; d_wdata=0; err=0; err_code=0; err_address=0; counter=0.
REQ-035 Reset in ISSUE or WAIT SHALL abandon the transaction with no m_ack, and the next device ack SHALL be ignored.

Structure
REQ-036 The sc64 package SHALL hold the device ID constants, the bus_error_e enum (NONE, UNMAPPED, TIMEOUT, OVERRUN) and the default ID_LSB.
REQ-037 The timeout counter SHALL be a sub-module cpu_bus_timeout (load, enable, expired; width $clog2(TIMEOUT_CYCLES)).
REQ-038 The fabric SHALL instance no devices; cpu_soc connects slots by ID.

Verification
REQ-039 Read slot 3 (address 32'h0300_0010), device acks 1 cycle after d_request with 32'h1234_5678 -> d_request=16'h0008 at N+1, m_ack at N+2, m_rdata=32'h1234_5678.
REQ-040 Access ID 5 with DEVICE_MASK bit 5 = 0 -> m_ack 2 cycles later, m_rdata=FFFF_FFFF, err=1, err_code=1, err_address=32'h0500_0000.
REQ-041 Device never acks, TIMEOUT_CYCLES=8 -> m_ack with ERROR_DATA, err_code=2; a d_ack arriving 3 cycles later produces no m_ack.
REQ-042 Second m_request while in WAIT -> first transaction completes normally, second is dropped, err_code=3; err_clear then returns err to 0.
REQ-043 Reset asserted in WAIT, device acks after reset is released -> no m_ack, all outputs at reset values.
REQ-044 Acks from slots 1 and 2 in the same cycle while slot 2 is selected -> m_rdata comes from slot 2 only, single m_ack pulse.
